// File: rtl/multiplier_booth_r4_pkg.sv
// Shared definitions for the radix-4 Booth multiplier: default operand width,
// controller states and the Booth digit set with its triplet decoder.
package multiplier_booth_r4_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_BUSY
  } state_t;

  typedef enum logic [2:0] {
    DIG_ZERO,
    DIG_POS1,
    DIG_POS2,
    DIG_NEG1,
    DIG_NEG2
  } booth_digit_t;

  // Map a multiplier triplet {y[2i+1], y[2i], y[2i-1]} to its Booth digit.
  function automatic booth_digit_t decode_triplet(input logic [2:0] triplet);
    booth_digit_t digit;
    case (triplet)
      3'b001, 3'b010: digit = DIG_POS1;
      3'b011:         digit = DIG_POS2;
      3'b100:         digit = DIG_NEG2;
      3'b101, 3'b110: digit = DIG_NEG1;
      default:        digit = DIG_ZERO;
    endcase
    return digit;
  endfunction

endpackage

// File: rtl/multiplier_booth_r4_if.sv
// Operand/result bundle of the Booth multiplier. The master supplies X/Y and
// watches ready/valid/R; the slave is the multiplier itself.
interface multiplier_booth_r4_if
  import multiplier_booth_r4_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic                      ready;
  logic                      valid;
  logic signed [2*WIDTH-1:0] R;
  logic signed [WIDTH-1:0]   X;
  logic signed [WIDTH-1:0]   Y;

  modport master (
    output X,
    output Y,
    input  ready,
    input  valid,
    input  R
  );

  modport slave (
    input  X,
    input  Y,
    output ready,
    output valid,
    output R
  );

endinterface

// File: rtl/multiplier_booth_r4_booth_r4_encoder.sv
// Radix-4 Booth partial-product selector: turns one multiplier triplet and the
// multiplicand into 0, +-M or +-2M, sign-extended to 2*WIDTH+2 bits so that
// -2M of the most negative multiplicand is still representable.
module booth_r4_encoder
  import multiplier_booth_r4_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [2:0]               triplet,
  input  logic signed [WIDTH-1:0]  mcand,
  output logic signed [2*WIDTH+1:0] pp
);

  logic signed [2*WIDTH+1:0] m_ext;
  booth_digit_t              digit;

  assign m_ext = {{(WIDTH+2){mcand[WIDTH-1]}}, mcand};
  assign digit = decode_triplet(triplet);

  // Select the signed multiple of the multiplicand named by the Booth digit.
  always_comb begin
    pp = '0;
    case (digit)
      DIG_POS1: pp = m_ext;
      DIG_POS2: pp = m_ext <<< 1;
      DIG_NEG1: pp = -m_ext;
      DIG_NEG2: pp = -(m_ext <<< 1);
      default:  pp = '0;
    endcase
  end

endmodule

// File: rtl/multiplier_booth_r4.sv
// Self-timed sequential signed WIDTHxWIDTH multiplier, one radix-4 Booth digit
// per cycle, LSB first. Operands load whenever the block is idle; a product
// appears WIDTH/2 cycles later together with a one-cycle valid pulse.
module multiplier_booth_r4
  import multiplier_booth_r4_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  multiplier_booth_r4_if.slave bus
);

  localparam int             CW    = $clog2(WIDTH/2 + 1);
  localparam logic [CW-1:0]  STEPS = CW'(WIDTH/2);
  localparam logic [CW-1:0]  LAST  = CW'(1);

  state_t                    state_q, state_d;
  logic signed [WIDTH-1:0]   mcand_q, mcand_d;
  logic signed [WIDTH:0]     mplier_q, mplier_d;
  logic signed [2*WIDTH+1:0] acc_q, acc_d;
  logic [CW-1:0]             count_q, count_d;
  logic                      ready_q, ready_d;
  logic                      valid_q, valid_d;
  logic signed [2*WIDTH-1:0] r_q, r_d;

  logic signed [2*WIDTH+1:0] pp;
  logic signed [2*WIDTH+1:0] acc_step;

  booth_r4_encoder #(.WIDTH(WIDTH)) u_encoder (
    .triplet (mplier_q[2:0]),
    .mcand   (mcand_q),
    .pp      (pp)
  );

  // Partial products enter at bit WIDTH and the accumulator shifts right two
  // places per digit, so after WIDTH/2 steps digit i sits at weight 4^i and
  // no nonzero bit is ever shifted out the bottom.
  always_comb begin
    acc_step = (acc_q + (pp <<< WIDTH)) >>> 2;
  end

  // Controller: idle loads operands, busy retires one digit per cycle and
  // publishes the product on the final digit.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    ready_d  = ready_q;
    valid_d  = valid_q;
    r_d      = r_q;
    case (state_q)
      ST_INIT: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      ST_IDLE: begin
        mcand_d  = bus.X;
        mplier_d = {bus.Y, 1'b0};
        acc_d    = '0;
        count_d  = STEPS;
        ready_d  = 1'b0;
        valid_d  = 1'b0;
        state_d  = ST_BUSY;
      end
      ST_BUSY: begin
        acc_d    = acc_step;
        mplier_d = mplier_q >>> 2;
        count_d  = count_q - 1'b1;
        if (count_q == LAST) begin
          r_d     = acc_step[2*WIDTH-1:0];
          valid_d = 1'b1;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_INIT;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      r_q      <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      r_q      <= r_d;
    end
  end

  assign bus.ready = ready_q;
  assign bus.valid = valid_q;
  assign bus.R     = r_q;

endmodule

// File: tb/tb_multiplier_booth_r4.sv
// Self-checking bench for the radix-4 Booth multiplier: directed table of
// corner products, zero operands, mid-operation reset and a long run of
// back-to-back random products checked against plain integer multiplication.
module tb_multiplier_booth_r4;
  import multiplier_booth_r4_pkg::*;

  localparam int W       = 16;
  localparam int LATENCY = W/2 + 1;

  typedef struct {
    logic signed [W-1:0] x;
    logic signed [W-1:0] y;
    longint              exp;
    string               name;
  } vec_t;

  logic   clk;
  logic   rst;
  int     checks   = 0;
  int     failures = 0;
  longint last_exp = 0;
  vec_t   vecs[9];

  multiplier_booth_r4_if #(.WIDTH(W)) bus ();

  multiplier_booth_r4 #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint ref_mul(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    return longint'(a) * longint'(b);
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic signed [W-1:0] x, input logic signed [W-1:0] y);
    bus.X = x;
    bus.Y = y;
  endtask

  task automatic waitReady(input string name);
    int n = 0;
    while (bus.ready !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (bus.ready !== 1'b1) checkOutput({name, "_ready_timeout"}, 0, 1);
  endtask

  // Drive one operand pair while ready, then follow it to completion.
  task automatic runOperation(input logic signed [W-1:0] x, input logic signed [W-1:0] y,
                              input longint exp, input string name, input bit scramble);
    int lat  = 0;
    bit seen = 0;
    waitReady(name);
    applyStimulus(x, y);
    for (int k = 1; k <= 30 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checkOutput({name, "_busy_ready"}, longint'(bus.ready), 0);
        checkOutput({name, "_busy_valid"}, longint'(bus.valid), 0);
        checkOutput({name, "_r_hold"}, longint'(bus.R), last_exp);
      end
      if (bus.valid === 1'b1) begin
        seen = 1;
        lat  = k;
      end else if (scramble) begin
        applyStimulus(W'($urandom), W'($urandom));
      end
    end
    checkOutput({name, "_done"}, longint'(seen), 1);
    if (seen) begin
      checkOutput({name, "_latency"}, longint'(lat), longint'(LATENCY));
      checkOutput({name, "_R"}, longint'(bus.R), exp);
      checkOutput({name, "_ready"}, longint'(bus.ready), 1);
      last_exp = exp;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic signed [W-1:0] rx, ry;

    vecs[0] = '{x: -16'sd32767, y: -16'sd32767, exp: 64'sd1073676289,  name: "large_neg"};
    vecs[1] = '{x: 16'sd12345,  y: 16'sd0,      exp: 64'sd0,           name: "x_times_zero"};
    vecs[2] = '{x: -16'sd32768, y: -16'sd32768, exp: 64'sd1073741824,  name: "min_min"};
    vecs[3] = '{x: 16'sd32767,  y: -16'sd32768, exp: -64'sd1073709056, name: "max_min"};
    vecs[4] = '{x: -16'sd1,     y: 16'sd1,      exp: -64'sd1,          name: "neg1_pos1"};
    vecs[5] = '{x: 16'sd3,      y: -16'sd5,     exp: -64'sd15,         name: "small_mixed"};
    vecs[6] = '{x: 16'sd100,    y: 16'sd200,    exp: 64'sd20000,       name: "small_pos"};
    vecs[7] = '{x: -16'sd32768, y: 16'sd32767,  exp: -64'sd1073709056, name: "min_max"};
    vecs[8] = '{x: 16'sd32767,  y: 16'sd32767,  exp: 64'sd1073676289,  name: "max_max"};

    rst = 1'b0;
    applyStimulus('0, '0);
    repeat (3) @(negedge clk);
    checkOutput("reset_ready", longint'(bus.ready), 0);
    checkOutput("reset_valid", longint'(bus.valid), 0);
    checkOutput("reset_R", longint'(bus.R), 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("init_ready", longint'(bus.ready), 1);
    checkOutput("init_valid", longint'(bus.valid), 0);

    for (int i = 0; i < 9; i++) begin
      runOperation(vecs[i].x, vecs[i].y, vecs[i].exp, vecs[i].name, 1'b0);
    end

    for (int i = 0; i < 5; i++) begin
      rx = W'($urandom);
      runOperation(rx, '0, ref_mul(rx, '0), "rand_x_zero", 1'b1);
    end

    rx = W'($urandom);
    ry = W'($urandom);
    waitReady("midop");
    applyStimulus(rx, ry);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midop_reset_ready", longint'(bus.ready), 0);
    checkOutput("midop_reset_valid", longint'(bus.valid), 0);
    checkOutput("midop_reset_R", longint'(bus.R), 0);
    last_exp = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midop_init_ready", longint'(bus.ready), 1);
    rx = W'($urandom);
    ry = W'($urandom);
    runOperation(rx, ry, ref_mul(rx, ry), "after_reset", 1'b0);

    for (int i = 0; i < 112; i++) begin
      rx = W'($urandom);
      ry = W'($urandom);
      runOperation(rx, ry, ref_mul(rx, ry), "b2b_rand", 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
